fft_power_avg: RTL

- Streaming post-processor that sits directly after the FFT core's output AXI-Stream.
- Computes the per-bin power |X[k]|^2 from complex fixed-point samples.
- Accumulates power over 2^AVG_LOG2 consecutive frames in an internal per-bin RAM.
- Emits one averaged power-spectrum frame per group, with bin index on tuser and tlast-framing checks.

---
 rtl/fft_power_avg.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fft_power_avg.sv
// Streaming |X[k]|^2 post-processor: accumulates per-bin power over 2^AVG_LOG2 frames.
// Optional FFT_AVG_NORM_EN: output is the mean (sum >> AVG_LOG2) instead of the raw sum.
`timescale 1ns/1ps
module fft_power_avg #(
   parameter int DATA_W   = 16,
   parameter int FFT_LEN  = 1024,
   parameter int AVG_LOG2 = 2,
   localparam int P_W     = 2 * DATA_W,
   localparam int A_W     = P_W + AVG_LOG2,
   localparam int IDX_W   = $clog2(FFT_LEN),
`ifdef FFT_AVG_NORM_EN
   localparam int O_W     = P_W
`else
   localparam int O_W     = A_W
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2*DATA_W-1:0] s_axis_tdata,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   input  logic                s_axis_tlast,
   output logic [O_W-1:0]      m_axis_tdata,
   output logic [IDX_W-1:0]    m_axis_tuser,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                m_axis_tlast,
   output logic                err_tlast_missing,
   output logic                err_tlast_unexpected
);

   localparam int FRM_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [IDX_W-1:0] BIN_LAST = IDX_W'(FFT_LEN - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'((1 << AVG_LOG2) - 1);

   logic                     en_s, accept_s, bin_last_s;
   logic signed [DATA_W-1:0] re_s, im_s;
   logic signed [P_W-1:0]    re_sq_s, im_sq_s;
   logic [A_W-1:0]           acc_s;

   logic [IDX_W-1:0] bin_cnt_q, bin_cnt_d;
   logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             v1_q, v1_d, last1_q, last1_d;
   logic [P_W-1:0]   re2_q, re2_d, im2_q, im2_d;
   logic [IDX_W-1:0] bin1_q, bin1_d;
   logic [FRM_W-1:0] frm1_q, frm1_d;
   logic             v2_q, v2_d, last2_q, last2_d;
   logic [P_W-1:0]   p2_q, p2_d;
   logic [IDX_W-1:0] bin2_q, bin2_d;
   logic [FRM_W-1:0] frm2_q, frm2_d;
   logic [A_W-1:0]   rd2_q;
   logic             m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
   logic [O_W-1:0]   m_tdata_q, m_tdata_d;
   logic [IDX_W-1:0] m_tuser_q, m_tuser_d;
   logic             err_miss_q, err_miss_d, err_unexp_q, err_unexp_d;
   logic [A_W-1:0]   ram_q [FFT_LEN];

   // Only a held emitting beat can stall; the whole pipeline freezes with it.
   assign en_s       = !(m_tvalid_q && !m_axis_tready);
   assign accept_s   = s_axis_tvalid && en_s;
   assign bin_last_s = (bin_cnt_q == BIN_LAST);
   assign re_s       = s_axis_tdata[DATA_W-1:0];
   assign im_s       = s_axis_tdata[2*DATA_W-1:DATA_W];
   assign re_sq_s    = re_s * re_s;
   assign im_sq_s    = im_s * im_s;
   assign acc_s      = (frm2_q == '0) ? A_W'(p2_q) : (rd2_q + A_W'(p2_q));

   assign s_axis_tready        = en_s;
   assign m_axis_tdata         = m_tdata_q;
   assign m_axis_tuser         = m_tuser_q;
   assign m_axis_tvalid        = m_tvalid_q;
   assign m_axis_tlast         = m_tlast_q;
   assign err_tlast_missing    = err_miss_q;
   assign err_tlast_unexpected = err_unexp_q;

   // Bin/frame counters and framing-error detection, advancing on accept only.
   always_comb begin
      bin_cnt_d   = bin_cnt_q;
      frame_cnt_d = frame_cnt_q;
      err_miss_d  = accept_s && bin_last_s && !s_axis_tlast;
      err_unexp_d = accept_s && !bin_last_s && s_axis_tlast;
      if (accept_s) begin
         if (s_axis_tlast && !bin_last_s) begin
            bin_cnt_d   = '0;
            frame_cnt_d = '0;
         end else if (bin_last_s) begin
            bin_cnt_d   = '0;
            frame_cnt_d = (frame_cnt_q == FRM_LAST) ? '0 : (frame_cnt_q + FRM_W'(1));
         end else begin
            bin_cnt_d   = bin_cnt_q + IDX_W'(1);
         end
      end else begin
         bin_cnt_d   = bin_cnt_q;
         frame_cnt_d = frame_cnt_q;
      end
   end

   // Three-stage datapath: squares, power sum, accumulate and present.
   always_comb begin
      v1_d = v1_q;  re2_d = re2_q;  im2_d = im2_q;
      bin1_d = bin1_q;  frm1_d = frm1_q;  last1_d = last1_q;
      v2_d = v2_q;  p2_d = p2_q;  bin2_d = bin2_q;  frm2_d = frm2_q;  last2_d = last2_q;
      m_tvalid_d = m_tvalid_q;  m_tdata_d = m_tdata_q;
      m_tuser_d = m_tuser_q;  m_tlast_d = m_tlast_q;
      if (en_s) begin
         v1_d    = accept_s;
         re2_d   = P_W'(re_sq_s);
         im2_d   = P_W'(im_sq_s);
         bin1_d  = bin_cnt_q;
         frm1_d  = frame_cnt_q;
         last1_d = bin_last_s || s_axis_tlast;
         v2_d    = v1_q;
         p2_d    = re2_q + im2_q;
         bin2_d  = bin1_q;
         frm2_d  = frm1_q;
         last2_d = last1_q;
         m_tvalid_d = v2_q && (frm2_q == FRM_LAST);
`ifdef FFT_AVG_NORM_EN
         m_tdata_d  = P_W'(acc_s >> AVG_LOG2);
`else
         m_tdata_d  = acc_s;
`endif
         m_tuser_d  = bin2_q;
         m_tlast_d  = last2_q;
      end else begin
         v1_d       = v1_q;
         v2_d       = v2_q;
         m_tvalid_d = m_tvalid_q;
      end
   end

   // Accumulator RAM: registered read at S2, bubble-free write at S3; not reset.
   always_ff @(posedge clk) begin
      if (en_s) begin
         rd2_q <= ram_q[bin1_q];
      end
      if (en_s && v2_q) begin
         ram_q[bin2_q] <= acc_s;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_cnt_q <= '0;  frame_cnt_q <= '0;
         v1_q <= 1'b0;  re2_q <= '0;  im2_q <= '0;
         bin1_q <= '0;  frm1_q <= '0;  last1_q <= 1'b0;
         v2_q <= 1'b0;  p2_q <= '0;  bin2_q <= '0;  frm2_q <= '0;  last2_q <= 1'b0;
         m_tvalid_q <= 1'b0;  m_tdata_q <= '0;  m_tuser_q <= '0;  m_tlast_q <= 1'b0;
         err_miss_q <= 1'b0;  err_unexp_q <= 1'b0;
      end else begin
         bin_cnt_q <= bin_cnt_d;  frame_cnt_q <= frame_cnt_d;
         v1_q <= v1_d;  re2_q <= re2_d;  im2_q <= im2_d;
         bin1_q <= bin1_d;  frm1_q <= frm1_d;  last1_q <= last1_d;
         v2_q <= v2_d;  p2_q <= p2_d;  bin2_q <= bin2_d;  frm2_q <= frm2_d;  last2_q <= last2_d;
         m_tvalid_q <= m_tvalid_d;  m_tdata_q <= m_tdata_d;
         m_tuser_q <= m_tuser_d;  m_tlast_q <= m_tlast_d;
         err_miss_q <= err_miss_d;  err_unexp_q <= err_unexp_d;
      end
   end

endmodule
